// File: rtl/alu_seq_param.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_param
// Purpose  : Multi-cycle sequential ALU with a WIDTH-bit datapath. It sits
//            between the control sequencer and the shared data bus. After
//            start, the M word and then the Q word arrive serially on inbus.
//            The block executes the operation and returns one or two
//            registered words on outbus, together with registered NZCV flags.
//            ADD/SUB/logic ops take one EXEC cycle. Booth MUL and restoring
//            DIV take WIDTH EXEC cycles. Shifts take one EXEC cycle per bit.
// Ports    : clk            rising-edge clock
//            rst_b          asynchronous active-low reset
//            start          begin operation (sampled only in IDLE)
//            s[3:0]         opcode, captured with start
//            inbus[W-1:0]   operand bus (M, then Q)
//            outbus[W-1:0]  registered result word
//            negative/zero/carry/overflow  registered flags
//            finish         one-cycle strobe with the final result word
//            busy           high whenever not IDLE
// Options  : define ALU_ROTATE_EN to enable ROL (1011) and ROR (1100)
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_param #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [3:0]       s,
  input  logic [WIDTH-1:0] inbus,
  output logic [WIDTH-1:0] outbus,
  output logic             negative,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             finish,
  output logic             busy
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_MUL = 4'b0110;
  localparam logic [3:0] OP_DIV = 4'b0111;
  localparam logic [3:0] OP_SHL = 4'b1000;
  localparam logic [3:0] OP_SHR = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;
`ifdef ALU_ROTATE_EN
  localparam logic [3:0] OP_ROL = 4'b1011;
  localparam logic [3:0] OP_ROR = 4'b1100;
`endif
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_M = 3'd1,
    ST_LOAD_Q = 3'd2,
    ST_EXEC   = 3'd3,
    ST_OUT_HI = 3'd4,
    ST_OUT_LO = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH:0]     a_q, a_d;       // extra bit keeps Booth and divide steps overflow-free
  logic               q1_q, q1_d;     // Booth q(-1) bit
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   outbus_q, outbus_d;
  logic               n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;
  logic               finish_q, finish_d;

  // Single-cycle datapath
  logic               add_sub;
  logic [WIDTH-1:0]   add_b;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v;

  always_comb begin
    add_sub = (op_q == OP_SUB);
    add_b   = add_sub ? ~m_q : m_q;
    add_sum = {1'b0, q_q} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_sub};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        alu_res = add_sum[WIDTH-1:0];
        alu_c   = add_sum[WIDTH];
        alu_v   = (q_q[WIDTH-1] == add_b[WIDTH-1]) && (add_sum[WIDTH-1] != q_q[WIDTH-1]);
      end
      OP_AND:  alu_res = q_q & m_q;
      OP_OR:   alu_res = q_q | m_q;
      OP_XOR:  alu_res = q_q ^ m_q;
      OP_NOT:  alu_res = ~q_q;
      default: alu_res = '0;
    endcase
  end

  // One Booth step and one restoring-divide step
  logic [WIDTH:0]     m_ext, booth_sum, mul_a_nx, div_sh, div_diff, div_a_nx;
  logic [WIDTH-1:0]   mul_q_nx, div_q_nx;
  logic               div_ok;

  always_comb begin
    m_ext = {m_q[WIDTH-1], m_q};
    case ({q_q[0], q1_q})
      2'b01:   booth_sum = a_q + m_ext;
      2'b10:   booth_sum = a_q - m_ext;
      default: booth_sum = a_q;
    endcase
    mul_a_nx = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    mul_q_nx = {booth_sum[0], q_q[WIDTH-1:1]};
    div_sh   = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, m_q};
    div_ok   = ~div_diff[WIDTH];
    div_a_nx = div_ok ? div_diff : div_sh;
    div_q_nx = {q_q[WIDTH-2:0], div_ok};
  end

  // One-bit shift / rotate step
  logic               is_shift;
  logic [WIDTH-1:0]   shift_nx;
  logic               rot_c_nx;

  always_comb begin
    is_shift = 1'b0;
    shift_nx = q_q;
    rot_c_nx = 1'b0;
    case (op_q)
      OP_SHL: begin is_shift = 1'b1; shift_nx = {q_q[WIDTH-2:0], 1'b0}; end
      OP_SHR: begin is_shift = 1'b1; shift_nx = {1'b0, q_q[WIDTH-1:1]}; end
      OP_SRA: begin is_shift = 1'b1; shift_nx = {q_q[WIDTH-1], q_q[WIDTH-1:1]}; end
`ifdef ALU_ROTATE_EN
      OP_ROL: begin
        is_shift = 1'b1;
        shift_nx = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        rot_c_nx = q_q[WIDTH-1];
      end
      OP_ROR: begin
        is_shift = 1'b1;
        shift_nx = {q_q[0], q_q[WIDTH-1:1]};
        rot_c_nx = q_q[0];
      end
`endif
      default: ;
    endcase
  end

  logic [CNT_W-1:0]   shamt, cnt_inc;
  logic               is_muldiv;
  logic               fin_load;
  logic [WIDTH-1:0]   fin_res;
  logic               fin_c, fin_v, fin_hi_n, fin_hi_z;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    m_d      = m_q;
    q_d      = q_q;
    a_d      = a_q;
    q1_d     = q1_q;
    cnt_d    = cnt_q;
    outbus_d = outbus_q;
    n_d      = n_q;
    z_d      = z_q;
    c_d      = c_q;
    v_d      = v_q;
    finish_d = 1'b0;
    fin_load = 1'b0;
    fin_res  = '0;
    fin_c    = 1'b0;
    fin_v    = 1'b0;
    fin_hi_n = 1'b0;
    fin_hi_z = 1'b0;
    shamt     = m_q[CNT_W-1:0];
    cnt_inc   = cnt_q + CNT_W'(1);
    is_muldiv = (op_q == OP_MUL) || (op_q == OP_DIV);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = s;
          state_d = ST_LOAD_M;
        end
      end
      ST_LOAD_M: begin
        m_d     = inbus;
        state_d = ST_LOAD_Q;
      end
      ST_LOAD_Q: begin
        q_d   = inbus;
        a_d   = '0;
        q1_d  = 1'b0;
        cnt_d = '0;
        // A zero shift amount has nothing to execute: Q goes straight out.
        if (is_shift && (shamt == '0)) begin
          state_d  = ST_OUT_LO;
          fin_load = 1'b1;
          fin_res  = inbus;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (op_q == OP_MUL) begin
          a_d   = mul_a_nx;
          q_d   = mul_q_nx;
          q1_d  = q_q[0];
          cnt_d = cnt_inc;
          if (cnt_q == CNT_MAX) begin
            state_d  = ST_OUT_HI;
            outbus_d = mul_a_nx[WIDTH-1:0];
          end
        end else if (op_q == OP_DIV) begin
          a_d   = div_a_nx;
          q_d   = div_q_nx;
          cnt_d = cnt_inc;
          if (cnt_q == CNT_MAX) begin
            state_d  = ST_OUT_HI;
            outbus_d = div_q_nx;
          end
        end else if (is_shift) begin
          q_d   = shift_nx;
          cnt_d = cnt_inc;
          if (cnt_inc == shamt) begin
            state_d  = ST_OUT_LO;
            fin_load = 1'b1;
            fin_res  = shift_nx;
            fin_c    = rot_c_nx;
          end
        end else begin
          state_d  = ST_OUT_LO;
          fin_load = 1'b1;
          fin_res  = alu_res;
          fin_c    = alu_c;
          fin_v    = alu_v;
        end
      end
      ST_OUT_HI: begin
        state_d  = ST_OUT_LO;
        fin_load = 1'b1;
        if (op_q == OP_MUL) begin
          fin_res  = q_q;
          fin_hi_n = a_q[WIDTH-1];
          fin_hi_z = ({a_q[WIDTH-1:0], q_q} == '0);
        end else begin
          fin_res  = a_q[WIDTH-1:0];
          fin_hi_n = q_q[WIDTH-1];
          fin_hi_z = (q_q == '0);
          fin_v    = (m_q == '0);
        end
      end
      ST_OUT_LO: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (fin_load) begin
      outbus_d = fin_res;
      finish_d = 1'b1;
      c_d      = fin_c;
      v_d      = fin_v;
      // Two-word results take N/Z from the product or the quotient.
      n_d      = is_muldiv ? fin_hi_n : fin_res[WIDTH-1];
      z_d      = is_muldiv ? fin_hi_z : (fin_res == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      m_q      <= '0;
      q_q      <= '0;
      a_q      <= '0;
      q1_q     <= 1'b0;
      cnt_q    <= '0;
      outbus_q <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      m_q      <= m_d;
      q_q      <= q_d;
      a_q      <= a_d;
      q1_q     <= q1_d;
      cnt_q    <= cnt_d;
      outbus_q <= outbus_d;
      n_q      <= n_d;
      z_q      <= z_d;
      c_q      <= c_d;
      v_q      <= v_d;
      finish_q <= finish_d;
    end
  end

  assign outbus   = outbus_q;
  assign negative = n_q;
  assign zero     = z_q;
  assign carry    = c_q;
  assign overflow = v_q;
  assign finish   = finish_q;
  assign busy     = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/alu_seq_param.md
Name: alu_seq_param

Overview:
Parametrised multi-cycle sequential ALU; next generation of the 16-bit ALU, generalised to WIDTH bits.
- Operands arrive serially over inbus after start: M word first, then Q word.
- Executes add/sub/logic in one cycle, signed Booth multiply and unsigned restoring divide in WIDTH cycles, and shifts in one cycle per bit position.
- Results leave on a registered outbus (one or two words) with finish and registered NZCV flags.
- Sits between the processor control sequencer and the shared data bus.

Parameters:
WIDTH, 16, datapath / bus width in bits (>=4, power of two)
CNT_W, $clog2(WIDTH), iteration counter width, also the shift-amount field width

Ports:
clk  input  1  system clock, rising edge
rst_b  input  1  asynchronous active-low reset
start  input  1  begin operation; sampled only in IDLE
s  input  4  opcode, captured on the start cycle
inbus  input  WIDTH  operand bus: M in LOAD_M, Q in LOAD_Q
outbus  output  WIDTH  registered result word
negative  output  1  registered result sign
zero  output  1  registered all-zero result
carry  output  1  registered adder carry-out (ADD/SUB only, else 0)
overflow  output  1  registered signed overflow (ADD/SUB) or divide-by-zero
finish  output  1  high for one cycle with the final result word
busy  output  1  high in every state except IDLE

Behaviour:
- Reset: async, active-low. Forces IDLE; outbus, flags, finish, busy, M, Q, A and counter all go to 0. Reset mid-operation aborts the operation with no output.
- Opcodes (result written as Q op M):
  - 0000 ADD: Q+M
  - 0001 SUB: Q−M (two's complement, carry=1 means no borrow)
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 NOT: ~Q
  - 0110 MUL: signed Booth radix-2, 2·WIDTH product
  - 0111 DIV: unsigned Q/M, gives quotient and remainder
  - 1000 SHL, 1001 SHR logical, 1010 SRA: Q shifted by M[CNT_W-1:0]
  - Others: reserved; result 0, flags from 0, single word.
- FSM states: IDLE → LOAD_M → LOAD_Q → EXEC → OUT_HI (MUL/DIV only) → OUT_LO → IDLE.
  - IDLE: when start=1, latch s and go to LOAD_M. A start outside IDLE is ignored.
  - LOAD_M (cycle 1): M <= inbus.
  - LOAD_Q (cycle 2): Q <= inbus; A and counter cleared.
  - EXEC: 1 cycle for opcodes 0000–0101 and reserved codes; exactly WIDTH cycles for MUL/DIV; k cycles for shifts, k = M[CNT_W-1:0]. When k=0, EXEC is skipped and the result is Q unchanged.
  - OUT_HI: outbus <= MUL product high word / DIV quotient; finish=0.
  - OUT_LO: outbus <= low word / remainder / single result; finish=1; flags updated at the same edge.
- Latency from the start cycle (cycle 0) to finish:
  - Single-cycle ops: cycle 4.
  - MUL/DIV: cycle 4+WIDTH (OUT_HI at 3+WIDTH).
  - Shifts: cycle 4+k−1 for k>=1, and cycle 3 for k=0.
- outbus and flags hold their values until the next operation writes them.
- Flags:
  - N = MSB of the final result. For MUL this is the product MSB; for DIV it is the quotient MSB.
  - Z = entire result zero. For MUL this covers both words; for DIV it covers the quotient only.
  - C and V are computed from the WIDTH-bit adder. V = operand signs equal and result sign differs. C and V are 0 for non-arithmetic ops.
- Divide by zero (M=0): no iteration is skipped. Quotient = all ones, remainder = Q, overflow=1.
- MUL uses an A:Q:q_1 arithmetic-shift-right structure; the product is A:Q.
- DIV uses a restoring step with a WIDTH+1-bit A register.

Optional Feature:
ALU_ROTATE_EN:
- Defined: opcodes 1011 ROL and 1100 ROR rotate Q by M[CNT_W-1:0]. Timing is identical to shifts; carry = last bit rotated out.
- Undefined: 1011 and 1100 are reserved (result 0).

Test Plan:
- ADD, WIDTH=16, M=0x0001, Q=0x7FFF → outbus=0x8000, N=1, Z=0, C=0, V=1, finish at cycle 4, busy cycles 1–4.
- SUB, M=0x0005, Q=0x0005 → 0x0000, Z=1, C=1, V=0; then AND with M=0x0F0F, Q=0x33FF → 0x030F, C=V=0.
- MUL, M=0xFFFD, Q=0x0007 → OUT_HI 0xFFFF at cycle 19, OUT_LO 0xFFEB with finish at cycle 20, N=1.
- DIV, M=7, Q=100 → 0x000E then 0x0002. DIV with M=0, Q=100 → 0xFFFF then 0x0064, V=1.
- SRA, M=3, Q=0x8000 → 0xF000, finish at cycle 6. SHL with M=0 → Q unchanged, finish at cycle 3.
- rst_b pulsed low mid-MUL (cycle 10) → all outputs 0 immediately, no finish; a start one cycle after release runs a clean ADD. A start asserted while busy is ignored.
